// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C transaction sequencer: FSM states,
// transaction steps and the (m_start, m_stop) op codes understood by i2c_master.
package i2c_seq_pkg;

    localparam int MAX_LEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACC,
        WAIT_DONE,
        EVAL,
        RESP
    } state_t;

    typedef enum logic [3:0] {
        ST_START,
        ST_ADDR_W,
        ST_REG,
        ST_WDATA,
        ST_STOP1,
        ST_START2,
        ST_ADDR_R,
        ST_RDATA,
        ST_STOP
    } step_t;

    // Op codes as {m_start, m_stop}
    localparam logic [1:0] OP_START = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b11;

    function automatic logic [1:0] step_op(step_t s);
        case (s)
            ST_START, ST_START2: step_op = OP_START;
            ST_STOP1, ST_STOP:   step_op = OP_STOP;
            ST_RDATA:            step_op = OP_READ;
            default:             step_op = OP_WRITE;
        endcase
    endfunction

endpackage

// File: rtl/i2c_txn_sequencer_if.sv
// Command, response and byte-master signals of the transaction sequencer.
// Handshake: a command transfers on the clock edge where cmd_valid && cmd_ready;
// rsp_valid is a one-cycle pulse with no back-pressure, and its fields hold until the next one.
interface i2c_txn_sequencer_if;
    import i2c_seq_pkg::*;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [6:0]  cmd_dev_addr;
    logic [7:0]  cmd_reg_addr;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_nack;
    logic        rsp_timeout;
    logic        busy;
    logic [7:0]  m_tx_data;
    logic        m_start;
    logic        m_stop;
    logic        m_i2c_en;
    logic        m_ready;
    logic        m_tx_done;
    logic [7:0]  m_rx_data;
    state_t      dbg_state;

    modport slave (
        input  cmd_valid, cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_len, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, busy,
        output m_tx_data, m_start, m_stop, m_i2c_en,
        input  m_ready, m_tx_done, m_rx_data,
        output dbg_state
    );

    modport master (
        output cmd_valid, cmd_rw, cmd_dev_addr, cmd_reg_addr, cmd_len, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, busy,
        input  m_tx_data, m_start, m_stop, m_i2c_en,
        output m_ready, m_tx_done, m_rx_data,
        input  dbg_state
    );

endinterface

// File: rtl/i2c_txn_sequencer.sv
// Turns one register-level command into the START/addr/reg/data/STOP sequence of
// byte operations on i2c_master and returns a single response with read data and status.
module i2c_txn_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic                clk,
    input  logic                reset,
    i2c_txn_sequencer_if.slave  bus
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    state_t      state_q, state_n;
    step_t       step_q, step_n;
    logic [2:0]  cnt_q, cnt_n;
    logic [2:0]  len_q, len_n;
    logic        rw_q, rw_n;
    logic [6:0]  dev_q, dev_n;
    logic [7:0]  reg_q, reg_n;
    logic [31:0] wdata_q, wdata_n;
    logic [31:0] rdata_q, rdata_n;
    logic        nack_q, nack_n;
    logic [TW-1:0] timer_q, timer_n;

    logic        cmd_ready_q, cmd_ready_n;
    logic        busy_q, busy_n;
    logic        rsp_valid_q, rsp_valid_n;
    logic [31:0] rsp_rdata_q, rsp_rdata_n;
    logic        rsp_nack_q, rsp_nack_n;
    logic        rsp_timeout_q, rsp_timeout_n;
    logic [7:0]  tx_q, tx_n;
    logic        start_q, start_n;
    logic        stop_q, stop_n;
    logic        en_q, en_n;

    logic        issue, abort, last_byte;
    step_t       nxt_step;
    logic [7:0]  nxt_tx;
    logic [2:0]  eff_len;

    // Clamp to MAX_LEN; a zero-length read still fetches one byte
    always_comb begin
        eff_len = (bus.cmd_len > 3'(MAX_LEN)) ? 3'(MAX_LEN) : bus.cmd_len;
        if (bus.cmd_rw && eff_len == 3'd0) begin
            eff_len = 3'd1;
        end
    end

    always_comb begin
        state_n       = state_q;
        step_n        = step_q;
        cnt_n         = cnt_q;
        len_n         = len_q;
        rw_n          = rw_q;
        dev_n         = dev_q;
        reg_n         = reg_q;
        wdata_n       = wdata_q;
        rdata_n       = rdata_q;
        nack_n        = nack_q;
        timer_n       = timer_q;
        rsp_valid_n   = 1'b0;
        rsp_rdata_n   = rsp_rdata_q;
        rsp_nack_n    = rsp_nack_q;
        rsp_timeout_n = rsp_timeout_q;
        tx_n          = tx_q;
        start_n       = start_q;
        stop_n        = stop_q;
        en_n          = en_q;
        issue         = 1'b0;
        abort         = 1'b0;
        nxt_step      = ST_STOP;
        nxt_tx        = 8'h00;
        last_byte     = (3'(cnt_q + 3'd1) == len_q);

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    rw_n     = bus.cmd_rw;
                    dev_n    = bus.cmd_dev_addr;
                    reg_n    = bus.cmd_reg_addr;
                    wdata_n  = bus.cmd_wdata;
                    len_n    = eff_len;
                    cnt_n    = 3'd0;
                    rdata_n  = 32'h0;
                    nack_n   = 1'b0;
                    issue    = 1'b1;
                    nxt_step = ST_START;
                end
            end
            ISSUE: begin
                timer_n = '0;
                state_n = WAIT_ACC;
            end
            WAIT_ACC: begin
                // The master leaving ready is the only proof it took the op
                if (!bus.m_ready) begin
                    en_n    = 1'b0;
                    start_n = 1'b0;
                    stop_n  = 1'b0;
                    timer_n = timer_q + 1'b1;
                    state_n = WAIT_DONE;
                end else if (timer_q == TMAX) begin
                    abort = 1'b1;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (bus.m_ready) begin
                    state_n = EVAL;
                end else if (timer_q == TMAX) begin
                    abort = 1'b1;
                end else begin
                    timer_n = timer_q + 1'b1;
                end
            end
            EVAL: begin
                case (step_q)
                    ST_START: begin
                        issue    = 1'b1;
                        nxt_step = ST_ADDR_W;
                        nxt_tx   = {dev_q, 1'b0};
                    end
                    ST_ADDR_W: begin
                        issue = 1'b1;
                        if (!bus.m_tx_done) begin
                            nack_n   = 1'b1;
                            nxt_step = ST_STOP;
                        end else begin
                            nxt_step = ST_REG;
                            nxt_tx   = reg_q;
                        end
                    end
                    ST_REG: begin
                        issue = 1'b1;
                        if (!bus.m_tx_done) begin
                            nack_n   = 1'b1;
                            nxt_step = ST_STOP;
                        end else if (rw_q) begin
                            nxt_step = ST_STOP1;
                        end else if (len_q == 3'd0) begin
                            nxt_step = ST_STOP;
                        end else begin
                            cnt_n    = 3'd0;
                            nxt_step = ST_WDATA;
                            nxt_tx   = wdata_q[7:0];
                        end
                    end
                    ST_WDATA: begin
                        issue = 1'b1;
                        if (!bus.m_tx_done) begin
                            nack_n   = 1'b1;
                            nxt_step = ST_STOP;
                        end else if (last_byte) begin
                            nxt_step = ST_STOP;
                        end else begin
                            cnt_n    = 3'(cnt_q + 3'd1);
                            nxt_step = ST_WDATA;
                            nxt_tx   = wdata_q[{cnt_n[1:0], 3'b000} +: 8];
                        end
                    end
                    ST_STOP1: begin
                        issue    = 1'b1;
                        nxt_step = ST_START2;
                    end
                    ST_START2: begin
                        issue    = 1'b1;
                        nxt_step = ST_ADDR_R;
                        nxt_tx   = {dev_q, 1'b1};
                    end
                    ST_ADDR_R: begin
                        issue = 1'b1;
                        if (!bus.m_tx_done) begin
                            nack_n   = 1'b1;
                            nxt_step = ST_STOP;
                        end else begin
                            cnt_n    = 3'd0;
                            nxt_step = ST_RDATA;
                        end
                    end
                    ST_RDATA: begin
                        issue = 1'b1;
                        rdata_n[{cnt_q[1:0], 3'b000} +: 8] = bus.m_rx_data;
                        if (last_byte) begin
                            nxt_step = ST_STOP;
                        end else begin
                            cnt_n    = 3'(cnt_q + 3'd1);
                            nxt_step = ST_RDATA;
                        end
                    end
                    default: begin
                        state_n       = RESP;
                        rsp_valid_n   = 1'b1;
                        rsp_rdata_n   = nack_q ? 32'h0 : rdata_q;
                        rsp_nack_n    = nack_q;
                        rsp_timeout_n = 1'b0;
                    end
                endcase
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (issue) begin
            state_n           = ISSUE;
            step_n            = nxt_step;
            {start_n, stop_n} = step_op(nxt_step);
            tx_n              = nxt_tx;
            en_n              = 1'b1;
        end

        // A stuck op is abandoned without STOP; the parent must reset the master
        if (abort) begin
            state_n       = RESP;
            en_n          = 1'b0;
            start_n       = 1'b0;
            stop_n        = 1'b0;
            rsp_valid_n   = 1'b1;
            rsp_rdata_n   = 32'h0;
            rsp_nack_n    = nack_q;
            rsp_timeout_n = 1'b1;
        end

        cmd_ready_n = (state_n == IDLE);
        busy_n      = ~cmd_ready_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            step_q        <= ST_START;
            cnt_q         <= 3'd0;
            len_q         <= 3'd0;
            rw_q          <= 1'b0;
            dev_q         <= 7'h0;
            reg_q         <= 8'h0;
            wdata_q       <= 32'h0;
            rdata_q       <= 32'h0;
            nack_q        <= 1'b0;
            timer_q       <= '0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 32'h0;
            rsp_nack_q    <= 1'b0;
            rsp_timeout_q <= 1'b0;
            tx_q          <= 8'h0;
            start_q       <= 1'b0;
            stop_q        <= 1'b0;
            en_q          <= 1'b0;
        end else begin
            state_q       <= state_n;
            step_q        <= step_n;
            cnt_q         <= cnt_n;
            len_q         <= len_n;
            rw_q          <= rw_n;
            dev_q         <= dev_n;
            reg_q         <= reg_n;
            wdata_q       <= wdata_n;
            rdata_q       <= rdata_n;
            nack_q        <= nack_n;
            timer_q       <= timer_n;
            cmd_ready_q   <= cmd_ready_n;
            busy_q        <= busy_n;
            rsp_valid_q   <= rsp_valid_n;
            rsp_rdata_q   <= rsp_rdata_n;
            rsp_nack_q    <= rsp_nack_n;
            rsp_timeout_q <= rsp_timeout_n;
            tx_q          <= tx_n;
            start_q       <= start_n;
            stop_q        <= stop_n;
            en_q          <= en_n;
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.busy        = busy_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_nack    = rsp_nack_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.m_tx_data   = tx_q;
    assign bus.m_start     = start_q;
    assign bus.m_stop      = stop_q;
    assign bus.m_i2c_en    = en_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer with a behavioural byte-master model and
// scoreboard queues for master ops and responses.
module tb_i2c_txn_sequencer;
    import i2c_seq_pkg::*;

    localparam int TO_CYC = 16384;

    logic clk;
    logic reset;

    i2c_txn_sequencer_if bus();

    i2c_txn_sequencer #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    // {m_start, m_stop, byte}; byte is only meaningful for WRITE ops
    logic [9:0]  exp_op_q[$];
    // {timeout, nack, rdata}
    logic [33:0] exp_rsp_q[$];
    logic [7:0]  rd_q[$];

    bit stall = 1'b0;
    int nack_at = -1;
    int wr_total = 0;
    int ops_started = 0;
    int busy_cnt = 0;
    bit in_flight = 1'b0;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // byte-master model: ready in IDLE/HOLD, busy 3 cycles per op
    always @(posedge clk) begin
        if (reset) begin
            bus.m_ready   <= 1'b1;
            bus.m_tx_done <= 1'b0;
            bus.m_rx_data <= 8'h00;
            busy_cnt      <= 0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) bus.m_ready <= 1'b1;
        end else if (bus.m_i2c_en && bus.m_ready && !stall) begin
            bus.m_ready <= 1'b0;
            busy_cnt    <= 3;
            ops_started <= ops_started + 1;
            if ({bus.m_start, bus.m_stop} == 2'b00) begin
                bus.m_tx_done <= (wr_total != nack_at);
                wr_total      <= wr_total + 1;
            end else if ({bus.m_start, bus.m_stop} == 2'b11) begin
                bus.m_rx_data <= (rd_q.size() != 0) ? rd_q.pop_front() : 8'hEE;
                bus.m_tx_done <= 1'b1;
            end
        end
    end

    // monitor: ops taken by the master, responses, acceptance rule
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.m_i2c_en && bus.m_ready && !stall && busy_cnt == 0) begin
                if (exp_op_q.size() == 0) begin
                    check("unexpected_op", 64'({bus.m_start, bus.m_stop, bus.m_tx_data}), 64'h3FF);
                end else begin
                    logic [9:0] e;
                    logic [9:0] a;
                    e = exp_op_q.pop_front();
                    a = {bus.m_start, bus.m_stop,
                         ({bus.m_start, bus.m_stop} == 2'b00) ? bus.m_tx_data : 8'h00};
                    check("master_op", 64'(a), 64'(e));
                end
            end
            if (bus.rsp_valid) begin
                in_flight = 1'b0;
                if (exp_rsp_q.size() == 0) begin
                    check("unexpected_rsp", 64'({bus.rsp_timeout, bus.rsp_nack, bus.rsp_rdata}), 64'h3_FFFF_FFFF);
                end else begin
                    check("response", 64'({bus.rsp_timeout, bus.rsp_nack, bus.rsp_rdata}),
                          64'(exp_rsp_q.pop_front()));
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                check("accept_while_busy", 64'({in_flight, bus.busy}), 64'h0);
                in_flight = 1'b1;
            end
        end
    end

    // driver helpers
    task automatic op_start();        exp_op_q.push_back({OP_START, 8'h00}); endtask
    task automatic op_stop();         exp_op_q.push_back({OP_STOP,  8'h00}); endtask
    task automatic op_rd();           exp_op_q.push_back({OP_READ,  8'h00}); endtask
    task automatic op_wr(input logic [7:0] d); exp_op_q.push_back({OP_WRITE, d}); endtask
    task automatic exp_rsp(input logic t, input logic n, input logic [31:0] d);
        exp_rsp_q.push_back({t, n, d});
    endtask

    task automatic set_cmd(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [2:0] len, input logic [31:0] wd);
        bus.cmd_rw       = rw;
        bus.cmd_dev_addr = dev;
        bus.cmd_reg_addr = rg;
        bus.cmd_len      = len;
        bus.cmd_wdata    = wd;
    endtask

    task automatic wait_accept(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 200000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200000) check({name, "_accept_timeout"}, 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string name, input logic rw, input logic [6:0] dev,
                        input logic [7:0] rg, input logic [2:0] len, input logic [31:0] wd);
        @(posedge clk);
        #1;
        set_cmd(rw, dev, rg, len, wd);
        bus.cmd_valid = 1'b1;
        wait_accept(name);
        bus.cmd_valid = 1'b0;
        set_cmd(1'b0, 7'h7F, 8'hFF, 3'd7, 32'hFFFF_FFFF);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_rsp_q.size() != 0 || !bus.cmd_ready) && n < 5000) begin
            n++;
            @(negedge clk);
        end
        check({name, "_drain"}, 64'(n < 5000), 64'd1);
        check({name, "_ops_left"}, 64'(exp_op_q.size()), 64'd0);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        bus.cmd_valid = 1'b0;
        set_cmd(1'b0, 7'h0, 8'h0, 3'd0, 32'h0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("rst_busy",      64'(bus.busy), 64'd0);
        check("rst_outputs",   64'({bus.rsp_valid, bus.rsp_nack, bus.rsp_timeout,
                                    bus.m_start, bus.m_stop, bus.m_i2c_en}), 64'd0);
        check("rst_data",      64'({bus.rsp_rdata, bus.m_tx_data}), 64'd0);
        check("rst_state",     64'(bus.dbg_state), 64'(IDLE));

        // write 2 bytes, all ACKed
        op_start(); op_wr(8'h90); op_wr(8'h01); op_wr(8'hEF); op_wr(8'hBE); op_stop();
        exp_rsp(1'b0, 1'b0, 32'h0);
        send("wr2", 1'b0, 7'h48, 8'h01, 3'd2, 32'h0000_BEEF);
        drain("wr2");

        // read 3 bytes
        rd_q.push_back(8'h12); rd_q.push_back(8'h34); rd_q.push_back(8'h56);
        op_start(); op_wr(8'h90); op_wr(8'h00); op_stop();
        op_start(); op_wr(8'h91); op_rd(); op_rd(); op_rd(); op_stop();
        exp_rsp(1'b0, 1'b0, 32'h0056_3412);
        send("rd3", 1'b1, 7'h48, 8'h00, 3'd3, 32'h0);
        drain("rd3");

        // address byte NACKed
        nack_at = wr_total;
        op_start(); op_wr(8'hA0); op_stop();
        exp_rsp(1'b0, 1'b1, 32'h0);
        send("nack", 1'b0, 7'h50, 8'h02, 3'd4, 32'h1122_3344);
        drain("nack");
        nack_at = -1;

        // pointer-only write
        op_start(); op_wr(8'h90); op_wr(8'h05); op_stop();
        exp_rsp(1'b0, 1'b0, 32'h0);
        send("wr0", 1'b0, 7'h48, 8'h05, 3'd0, 32'hDEAD_BEEF);
        drain("wr0");

        // zero-length read fetches one byte
        rd_q.push_back(8'hA5);
        op_start(); op_wr(8'h90); op_wr(8'h07); op_stop();
        op_start(); op_wr(8'h91); op_rd(); op_stop();
        exp_rsp(1'b0, 1'b0, 32'h0000_00A5);
        send("rd0", 1'b1, 7'h48, 8'h07, 3'd0, 32'h0);
        drain("rd0");

        // length 7 clamps to 4
        op_start(); op_wr(8'h90); op_wr(8'h10);
        op_wr(8'h11); op_wr(8'h22); op_wr(8'h33); op_wr(8'h44); op_stop();
        exp_rsp(1'b0, 1'b0, 32'h0);
        send("wr7", 1'b0, 7'h48, 8'h10, 3'd7, 32'h4433_2211);
        drain("wr7");

        // cmd_valid held through busy: second command waits, first is latched
        op_start(); op_wr(8'h90); op_wr(8'h30); op_wr(8'h5A); op_stop();
        exp_rsp(1'b0, 1'b0, 32'h0);
        rd_q.push_back(8'h01); rd_q.push_back(8'h02);
        op_start(); op_wr(8'h42); op_wr(8'h31); op_stop();
        op_start(); op_wr(8'h43); op_rd(); op_rd(); op_stop();
        exp_rsp(1'b0, 1'b0, 32'h0000_0201);
        @(posedge clk);
        #1;
        set_cmd(1'b0, 7'h48, 8'h30, 3'd1, 32'h0000_005A);
        bus.cmd_valid = 1'b1;
        wait_accept("held_a");
        set_cmd(1'b1, 7'h21, 8'h31, 3'd2, 32'h0);
        wait_accept("held_b");
        bus.cmd_valid = 1'b0;
        drain("held");

        // timeout: master never accepts the START
        stall = 1'b1;
        exp_rsp(1'b1, 1'b0, 32'h0);
        send("tmo", 1'b0, 7'h48, 8'h00, 3'd0, 32'h0);
        n = 0;
        @(negedge clk);
        n = 1;
        while (!bus.rsp_valid && n < TO_CYC + 100) begin
            n++;
            @(negedge clk);
        end
        check("tmo_latency", 64'(n >= TO_CYC && n <= TO_CYC + 4), 64'd1);
        check("tmo_en_low", 64'(bus.m_i2c_en), 64'd0);
        @(negedge clk);
        check("tmo_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        stall = 1'b0;
        drain("tmo");

        // reset while a data byte is in flight
        op_start(); op_wr(8'h90); op_wr(8'h22); op_wr(8'hAA);
        op_wr(8'hBB); op_wr(8'hCC); op_wr(8'hDD); op_stop();
        exp_rsp(1'b0, 1'b0, 32'h0);
        n = ops_started;
        send("mid", 1'b0, 7'h48, 8'h22, 3'd4, 32'hDDCC_BBAA);
        begin
            int k;
            k = 0;
            while (ops_started != n + 4 && k < 1000) begin
                k++;
                @(negedge clk);
            end
            check("mid_reached_data", 64'(ops_started - n), 64'd4);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        exp_op_q.delete();
        exp_rsp_q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        in_flight = 1'b0;
        @(negedge clk);
        check("mid_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        check("mid_busy",      64'(bus.busy), 64'd0);
        check("mid_outputs",   64'({bus.rsp_valid, bus.rsp_nack, bus.rsp_timeout,
                                    bus.m_start, bus.m_stop, bus.m_i2c_en}), 64'd0);
        check("mid_data",      64'({bus.rsp_rdata, bus.m_tx_data}), 64'd0);
        check("mid_state",     64'(bus.dbg_state), 64'(IDLE));

        op_start(); op_wr(8'h78); op_wr(8'h7F); op_wr(8'hC3); op_stop();
        exp_rsp(1'b0, 1'b0, 32'h0);
        send("post_rst", 1'b0, 7'h3C, 8'h7F, 3'd1, 32'h0000_00C3);
        drain("post_rst");

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_txn_sequencer.md
Name: i2c_txn_sequencer

Overview:
Transaction-level controller sitting between a register/bus front end and the byte-level I2C master (`i2c_master`).
- Takes one command: 7-bit device address, 8-bit register address, direction, length of 0-4 bytes, and 32-bit write data.
- Issues the full START / address / register / data / STOP sequence as a series of master byte operations.
- Returns one response carrying read data plus NACK and timeout flags.

Parameters:
MAX_LEN, 4, maximum data bytes per transaction (fixed by 32-bit data ports)
TIMEOUT_CYC, 16384, cycles allowed per master operation before abort (one byte at 250-cycle quarter-bit is about 9000 cycles)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&&cmd_ready
cmd_rw  in  1  0=write, 1=read
cmd_dev_addr  in  7  target device address
cmd_reg_addr  in  8  target register address
cmd_len  in  3  data byte count (see Behaviour)
cmd_wdata  in  32  write bytes; byte k = [8k+7:8k], byte 0 sent first
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  32  read bytes; first received byte in [7:0], unused bytes 0
rsp_nack  out  1  a write byte was not acknowledged (valid with rsp_valid)
rsp_timeout  out  1  a master operation exceeded TIMEOUT_CYC (valid with rsp_valid)
busy  out  1  ~cmd_ready
m_tx_data  out  8  byte to master
m_start  out  1  master op code bit
m_stop  out  1  master op code bit
m_i2c_en  out  1  master op strobe
m_ready  in  1  master idle/hold indicator
m_tx_done  in  1  master ACK-received flag
m_rx_data  in  8  master received byte

Behaviour:
- Reset (synchronous, active-high): FSM returns to IDLE from any state, including mid-transaction. No STOP is issued; the bench must also reset the master.
- Output reset values:
  - cmd_ready=1.
  - rsp_valid, rsp_nack, rsp_timeout, busy = 0.
  - rsp_rdata=0, m_tx_data=0.
  - m_start, m_stop, m_i2c_en = 0.
  - All outputs are registered.
- Master op encoding (m_start,m_stop) with m_i2c_en=1:
  - START = 1,0 (master in IDLE).
  - WRITE = 0,0 (in HOLD).
  - STOP = 0,1 (in HOLD).
  - READ = 1,1 (in HOLD).
- m_i2c_en is low at all other times. Holding it high in HOLD with code 00 starts an unintended write.
- Op handshake, identical for every op:
  - ISSUE: drive code and m_tx_data, with m_i2c_en=1.
  - WAIT_ACC: hold the code until m_ready==0, then drop m_i2c_en.
  - WAIT_DONE: wait for m_ready==1.
  - EVAL: sample m_tx_done for WRITE ops, or m_rx_data for READ ops.
  - The timeout counter clears in ISSUE and counts through WAIT_ACC and WAIT_DONE.
- Step sequence:
  - Write: START, WRITE {dev,0}, WRITE reg, WRITE data[0..n-1], STOP.
  - Read: START, WRITE {dev,0}, WRITE reg, STOP, START, WRITE {dev,1}, READ x n, STOP. No repeated start; the master does not support it.
- Length rules:
  - cmd_len latched at acceptance, then clamped to MAX_LEN when above it.
  - Write with len 0 is a pointer-only write.
  - Read with len 0 is treated as len 1.
- Command latching: all cmd_* fields are captured on acceptance. Later input changes are ignored. cmd_valid while busy is not accepted.
- NACK: m_tx_done==0 after any WRITE op sets the sticky nack flag. Remaining address/data writes are skipped; jump to STOP, then respond with rsp_nack=1 and rsp_rdata=0.
- Timeout: on expiry, drop m_i2c_en, respond immediately with rsp_timeout=1 and no STOP, then return to IDLE.
- Response: rsp_valid pulses exactly one cycle after the final STOP op's EVAL (or on timeout), together with rsp_rdata/rsp_nack/rsp_timeout. The fields hold until the next response. cmd_ready returns in the following cycle.
- Read byte i shifts into rsp_rdata[8i+7:8i]. READ ops produce no NACK (the master always ACKs).

Decomposition:
- Package i2c_seq_pkg:
  - FSM state enum (IDLE, ISSUE, WAIT_ACC, WAIT_DONE, EVAL, RESP).
  - Step enum (ST_START, ST_ADDR_W, ST_REG, ST_WDATA, ST_STOP1, ST_START2, ST_ADDR_R, ST_RDATA, ST_STOP).
  - Op-code constants (OP_START, OP_WRITE, OP_STOP, OP_READ).
  - MAX_LEN.
- No sub-module: a single FSM plus step register, byte counter and timeout counter. The master instance lives in the parent.

Test Plan:
- Write dev 0x48, reg 0x01, len 2, wdata 0x0000BEEF, slave ACKs all -> bytes 0x90, 0x01, 0xEF, 0xBE, then STOP; rsp_valid pulse with rsp_nack=0, rsp_timeout=0.
- Read dev 0x48, reg 0x00, len 3, slave returns 0x12, 0x34, 0x56 -> 0x90, 0x00, STOP, START, 0x91, 3 READs, STOP; rsp_rdata=0x00563412.
- Write dev 0x50, len 4, slave NACKs the address byte -> no reg/data bytes, STOP issued, rsp_nack=1, rsp_rdata=0.
- Master model holds m_ready high after START issue for TIMEOUT_CYC cycles -> rsp_timeout=1, m_i2c_en=0, cmd_ready=1 the next cycle.
- Edge lengths: write len 0 -> only 0x90, reg, STOP; read len 0 -> exactly 1 READ; len 7 -> clamped to 4 bytes; cmd_valid held during busy -> a second command is accepted only after rsp_valid.
- Reset asserted mid-data-byte -> next cycle all outputs at reset values, FSM in IDLE; a new command after resetting the master completes normally.
